// File: rtl/rv32i_pkg.sv
// RV32I constants and decode helpers shared by the decode stage and its sub-blocks.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_ENCODING = 32'h00000013;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_t;

  function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through, one
// synchronous write port, x0 hard-wired to zero.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Next-state of the array; writes to x0 are dropped.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != 5'd0)) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // Storage with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= '{default: 32'd0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-through lets decode see a writeback result in the same cycle.
  assign rd1 = (rs1 == 5'd0) ? 32'd0 :
               (wr_en && (wr_addr == rs1)) ? wr_data : regs_q[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 :
               (wr_en && (wr_addr == rs2)) ? wr_data : regs_q[rs2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, immediate generation and
// early branch/jump resolution that redirects fetch and squashes the wrong path.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR      = NOP_ENCODING,
  parameter logic [31:0] RESET_PC_PLUS4 = 32'h00000004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [31:0] i_instr_F,
  input  logic [31:0] i_PC_plus4_F,
  input  logic        i_wr_en_W,
  input  logic [4:0]  i_wr_addr_W,
  input  logic [31:0] i_wr_data_W,
  input  logic        i_fwd_a_D,
  input  logic        i_fwd_b_D,
  input  logic [31:0] i_ALU_result_M,
  output logic        o_sel_PC_D,
  output logic [31:0] o_PC_branch_D,
  output logic [31:0] o_rd1_D,
  output logic [31:0] o_rd2_D,
  output logic [31:0] o_imm_D,
  output logic [4:0]  o_rs1_D,
  output logic [4:0]  o_rs2_D,
  output logic [4:0]  o_rd_D,
  output logic [6:0]  o_opcode_D,
  output logic [2:0]  o_funct3_D,
  output logic        o_funct7b5_D,
  output logic [31:0] o_PC_plus4_D,
  output logic        o_valid_D
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] op_a, op_b, pc_d;
  logic        br_taken, redirect;

  // IF/ID next state: stall holds, a redirect squashes, otherwise load from fetch.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (!i_en) begin
      valid_d = valid_q;
    end else if (o_sel_PC_D) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d    = i_instr_F;
      pc_plus4_d = i_PC_plus4_F;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= RESET_PC_PLUS4;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign o_opcode_D   = instr_q[6:0];
  assign o_rd_D       = instr_q[11:7];
  assign o_funct3_D   = instr_q[14:12];
  assign o_rs1_D      = instr_q[19:15];
  assign o_rs2_D      = instr_q[24:20];
  assign o_funct7b5_D = instr_q[30];
  assign o_PC_plus4_D = pc_plus4_q;
  assign o_valid_D    = valid_q;

  register_file u_register_file (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (i_wr_en_W),
    .wr_addr (i_wr_addr_W),
    .wr_data (i_wr_data_W),
    .rs1     (o_rs1_D),
    .rs2     (o_rs2_D),
    .rd1     (o_rd1_D),
    .rd2     (o_rd2_D)
  );

  always_comb begin
    case (imm_type_of(o_opcode_D))
      IMM_I:   o_imm_D = {{20{instr_q[31]}}, instr_q[31:20]};
      IMM_S:   o_imm_D = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B:   o_imm_D = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
      IMM_U:   o_imm_D = {instr_q[31:12], 12'd0};
      IMM_J:   o_imm_D = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                          instr_q[20], instr_q[30:21], 1'b0};
      default: o_imm_D = 32'd0;
    endcase
  end

  assign op_a = i_fwd_a_D ? i_ALU_result_M : o_rd1_D;
  assign op_b = i_fwd_b_D ? i_ALU_result_M : o_rd2_D;
  assign pc_d = pc_plus4_q - 32'd4;

  always_comb begin
    case (o_funct3_D)
      F3_BEQ:  br_taken = (op_a == op_b);
      F3_BNE:  br_taken = (op_a != op_b);
      F3_BLT:  br_taken = ($signed(op_a) < $signed(op_b));
      F3_BGE:  br_taken = ($signed(op_a) >= $signed(op_b));
      F3_BLTU: br_taken = (op_a < op_b);
      F3_BGEU: br_taken = (op_a >= op_b);
      default: br_taken = 1'b0;
    endcase
  end

  assign o_PC_branch_D = (o_opcode_D == OP_JALR) ? ((op_a + o_imm_D) & ~32'h1)
                                                 : (pc_d + o_imm_D);

  assign redirect = ((o_opcode_D == OP_BRANCH) && br_taken) ||
                    (o_opcode_D == OP_JAL) || (o_opcode_D == OP_JALR);

  // Gated by the stall so a redirect fires once; reset suppresses it outright.
  assign o_sel_PC_D = rst & valid_q & i_en & redirect;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage against a behavioural model.
module tb_decode_stage;

  logic        clk, rst, i_en;
  logic [31:0] i_instr_F, i_PC_plus4_F;
  logic        i_wr_en_W;
  logic [4:0]  i_wr_addr_W;
  logic [31:0] i_wr_data_W;
  logic        i_fwd_a_D, i_fwd_b_D;
  logic [31:0] i_ALU_result_M;
  logic        o_sel_PC_D;
  logic [31:0] o_PC_branch_D, o_rd1_D, o_rd2_D, o_imm_D;
  logic [4:0]  o_rs1_D, o_rs2_D, o_rd_D;
  logic [6:0]  o_opcode_D;
  logic [2:0]  o_funct3_D;
  logic        o_funct7b5_D;
  logic [31:0] o_PC_plus4_D;
  logic        o_valid_D;

  decode_stage dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_instr_F(i_instr_F), .i_PC_plus4_F(i_PC_plus4_F),
    .i_wr_en_W(i_wr_en_W), .i_wr_addr_W(i_wr_addr_W), .i_wr_data_W(i_wr_data_W),
    .i_fwd_a_D(i_fwd_a_D), .i_fwd_b_D(i_fwd_b_D), .i_ALU_result_M(i_ALU_result_M),
    .o_sel_PC_D(o_sel_PC_D), .o_PC_branch_D(o_PC_branch_D), .o_rd1_D(o_rd1_D),
    .o_rd2_D(o_rd2_D), .o_imm_D(o_imm_D), .o_rs1_D(o_rs1_D), .o_rs2_D(o_rs2_D),
    .o_rd_D(o_rd_D), .o_opcode_D(o_opcode_D), .o_funct3_D(o_funct3_D),
    .o_funct7b5_D(o_funct7b5_D), .o_PC_plus4_D(o_PC_plus4_D), .o_valid_D(o_valid_D)
  );

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  logic        m_known = 1'b0;
  logic        exp_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] s;
    s = ins[31] ? 32'hFFFFFFFF : 32'h0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: return (s << 11) | 32'(ins[30:20]);
      7'h23: return (s << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
      7'h63: return (s << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                    | (32'(ins[11:8]) << 1);
      7'h37, 7'h17: return ins & 32'hFFFFF000;
      7'h6F: return (s << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                    | (32'(ins[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (i_wr_en_W && i_wr_addr_W == r) return i_wr_data_W;
    return m_regs[r];
  endfunction

  // Compare every output against the model while inputs are stable
  task automatic settle_check();
    logic [31:0] a, b, imm, tgt, pcd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        tk, jump;
    #2;
    op  = m_instr[6:0];
    f3  = m_instr[14:12];
    imm = ref_imm(m_instr);
    a   = i_fwd_a_D ? i_ALU_result_M : ref_read(m_instr[19:15]);
    b   = i_fwd_b_D ? i_ALU_result_M : ref_read(m_instr[24:20]);
    pcd = m_pc4 - 32'd4;
    tk  = 1'b0;
    if (f3 == 3'b000) tk = (a == b);
    if (f3 == 3'b001) tk = (a != b);
    if (f3 == 3'b100) tk = ($signed(a) < $signed(b));
    if (f3 == 3'b101) tk = ($signed(a) >= $signed(b));
    if (f3 == 3'b110) tk = (a < b);
    if (f3 == 3'b111) tk = (a >= b);
    jump = (op == 7'h6F) || (op == 7'h67);
    exp_sel = rst && m_valid && i_en && (jump || (op == 7'h63 && tk));
    tgt = (op == 7'h67) ? ((a + imm) & 32'hFFFFFFFE) : (pcd + imm);
    if (m_known) begin
      chk("sel", 32'(o_sel_PC_D), 32'(exp_sel));
      if (exp_sel) chk("target", o_PC_branch_D, tgt);
      chk("rd1", o_rd1_D, ref_read(m_instr[19:15]));
      chk("rd2", o_rd2_D, ref_read(m_instr[24:20]));
      chk("imm", o_imm_D, imm);
      chk("rs1", 32'(o_rs1_D), 32'(m_instr[19:15]));
      chk("rs2", 32'(o_rs2_D), 32'(m_instr[24:20]));
      chk("rd", 32'(o_rd_D), 32'(m_instr[11:7]));
      chk("opcode", 32'(o_opcode_D), 32'(op));
      chk("funct3", 32'(o_funct3_D), 32'(f3));
      chk("funct7b5", 32'(o_funct7b5_D), 32'(m_instr[30]));
      chk("pc4", o_PC_plus4_D, m_pc4);
      chk("valid", 32'(o_valid_D), 32'(m_valid));
    end
  endtask

  // Advance the model on the clock edge, then return to the driving edge
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
      m_instr = NOP;
      m_pc4   = 32'h4;
      m_valid = 1'b0;
      m_known = 1'b1;
    end else begin
      if (i_wr_en_W && i_wr_addr_W != 5'd0) m_regs[i_wr_addr_W] = i_wr_data_W;
      if (i_en) begin
        if (exp_sel) begin
          m_instr = NOP;
          m_valid = 1'b0;
        end else begin
          m_instr = i_instr_F;
          m_pc4   = i_PC_plus4_F;
          m_valid = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd7;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  op;
    case ($urandom_range(0, 9))
      0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h23;  3: op = 7'h63;
      4: op = 7'h6F;  5: op = 7'h67;  6: op = 7'h37;  7: op = 7'h17;
      8: op = 7'h63;  default: op = 7'($urandom);
    endcase
    ins = $urandom;
    ins[6:0]   = op;
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    rst = 1'b0; i_en = 1'b1; i_instr_F = NOP; i_PC_plus4_F = 32'h8;
    i_wr_en_W = 1'b0; i_wr_addr_W = 5'd0; i_wr_data_W = 32'd0;
    i_fwd_a_D = 1'b0; i_fwd_b_D = 1'b0; i_ALU_result_M = 32'd0;
    @(negedge clk);
    settle_check(); advance();
    settle_check(); advance();
    rst = 1'b1;
    settle_check();
    chk("rst_valid", 32'(o_valid_D), 32'd0);
    chk("rst_sel", 32'(o_sel_PC_D), 32'd0);
    chk("rst_opcode", 32'(o_opcode_D), 32'h13);
    chk("rst_pc4", o_PC_plus4_D, 32'h4);
    chk("rst_imm", o_imm_D, 32'd0);
    advance();

    // write-through: addi x1,x5,0 sees x5 being written this cycle
    i_instr_F = 32'h00028093; i_PC_plus4_F = 32'h8;
    settle_check(); advance();
    i_instr_F = 32'h00000093;
    i_wr_en_W = 1'b1; i_wr_addr_W = 5'd5; i_wr_data_W = 32'hDEADBEEF;
    settle_check(); chk("wt_rd1", o_rd1_D, 32'hDEADBEEF); advance();
    i_wr_addr_W = 5'd0; i_wr_data_W = 32'h12345678;
    settle_check(); advance();
    i_wr_en_W = 1'b0;
    settle_check(); chk("x0_rd1", o_rd1_D, 32'd0);

    // BEQ x1,x2,+16 at PC 0x100
    i_wr_en_W = 1'b1; i_wr_addr_W = 5'd1; i_wr_data_W = 32'd7;
    advance();
    i_wr_addr_W = 5'd2;
    i_instr_F = 32'h00208863; i_PC_plus4_F = 32'h104;
    settle_check(); advance();
    i_wr_en_W = 1'b0; i_instr_F = 32'h00100113; i_PC_plus4_F = 32'h114;
    settle_check();
    chk("beq_sel", 32'(o_sel_PC_D), 32'd1);
    chk("beq_target", o_PC_branch_D, 32'h110);
    advance();
    settle_check();
    chk("squash_valid", 32'(o_valid_D), 32'd0);
    chk("squash_opcode", 32'(o_opcode_D), 32'h13);

    // BLTU vs BLT with x3=0xFFFFFFFF, x4=1
    i_wr_en_W = 1'b1; i_wr_addr_W = 5'd3; i_wr_data_W = 32'hFFFFFFFF;
    advance();
    i_wr_addr_W = 5'd4; i_wr_data_W = 32'd1;
    i_instr_F = 32'h0041E863; i_PC_plus4_F = 32'h204;
    settle_check(); advance();
    i_wr_en_W = 1'b0; i_instr_F = 32'h0041C863; i_PC_plus4_F = 32'h208;
    settle_check(); chk("bltu_sel", 32'(o_sel_PC_D), 32'd0); advance();
    i_instr_F = NOP;
    settle_check(); chk("blt_sel", 32'(o_sel_PC_D), 32'd1); advance();

    // JALR x1, 4(x7) with forwarded base
    i_instr_F = 32'h004380E7; i_PC_plus4_F = 32'h300;
    settle_check(); advance();
    i_fwd_a_D = 1'b1; i_ALU_result_M = 32'h2003; i_instr_F = NOP;
    settle_check();
    chk("jalr_target", o_PC_branch_D, 32'h2006);
    chk("jalr_sel", 32'(o_sel_PC_D), 32'd1);
    advance();
    i_fwd_a_D = 1'b0;

    // taken BEQ held by a 3-cycle stall
    i_instr_F = 32'h00208863; i_PC_plus4_F = 32'h104;
    settle_check(); advance();
    i_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_instr_F = $urandom; i_PC_plus4_F = $urandom;
      settle_check();
      chk("stall_sel", 32'(o_sel_PC_D), 32'd0);
      chk("stall_opcode", 32'(o_opcode_D), 32'h63);
      chk("stall_pc4", o_PC_plus4_D, 32'h104);
      advance();
    end
    i_en = 1'b1; i_instr_F = 32'h00100113;
    settle_check(); chk("release_sel", 32'(o_sel_PC_D), 32'd1); advance();
    settle_check();
    chk("release_squash", 32'(o_valid_D), 32'd0);
    chk("release_sel_once", 32'(o_sel_PC_D), 32'd0);
    advance();

    // randomized phase
    for (int n = 0; n < 500; n++) begin
      rst            = ($urandom_range(0, 59) != 0);
      i_en           = ($urandom_range(0, 3) != 0);
      i_wr_en_W      = 1'($urandom_range(0, 1));
      i_wr_addr_W    = 5'($urandom_range(0, 7));
      i_wr_data_W    = pick_val();
      i_fwd_a_D      = 1'($urandom_range(0, 1));
      i_fwd_b_D      = 1'($urandom_range(0, 1));
      i_ALU_result_M = pick_val();
      i_instr_F      = rand_instr();
      i_PC_plus4_F   = $urandom;
      settle_check();
      advance();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage, directly downstream of fetch.
- Latches fetch's instruction and PC+4 in an IF/ID pipeline register and holds the 32x32 register file (write port driven from writeback).
- Decodes immediates and register fields for execute.
- Resolves branches/jumps in D and returns the select and target to fetch, squashing the wrong-path instruction fetched in the same cycle.

Parameters:
- NOP_INSTR, 32'h00000013, encoding loaded into IF/ID on reset/squash (addi x0,x0,0)
- RESET_PC_PLUS4, 32'h00000004, IF/ID PC+4 value after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
- i_en  in  1  IF/ID load enable; 0 = stall, same signal that stalls fetch
- i_instr_F  in  32  instruction from fetch
- i_PC_plus4_F  in  32  PC+4 from fetch
- i_wr_en_W  in  1  register file write enable
- i_wr_addr_W  in  5  write register index
- i_wr_data_W  in  32  write data
- i_fwd_a_D  in  1  select i_ALU_result_M for the rs1 branch/JALR operand
- i_fwd_b_D  in  1  select i_ALU_result_M for the rs2 branch operand
- i_ALU_result_M  in  32  memory-stage ALU result for forwarding
- o_sel_PC_D  out  1  redirect fetch to o_PC_branch_D
- o_PC_branch_D  out  32  redirect target
- o_rd1_D  out  32  rs1 read data (unforwarded)
- o_rd2_D  out  32  rs2 read data (unforwarded)
- o_imm_D  out  32  sign-extended immediate
- o_rs1_D, o_rs2_D, o_rd_D  out  5 each  register fields
- o_opcode_D  out  7  opcode
- o_funct3_D  out  3  funct3
- o_funct7b5_D  out  1  instr[30]
- o_PC_plus4_D  out  32  latched PC+4
- o_valid_D  out  1  1 = D holds a real (non-squashed) instruction

Behaviour:
- IF/ID register, updated on posedge clk, priority order:
  - rst==0: instr<=NOP_INSTR, PC+4<=RESET_PC_PLUS4, valid<=0.
  - else i_en==0: hold all fields.
  - else o_sel_PC_D==1: instr<=NOP_INSTR, valid<=0. This squashes the wrong-path instruction.
  - else: load i_instr_F and i_PC_plus4_F, valid<=1.
- Reset outputs: o_sel_PC_D=0, o_valid_D=0, fields decoded from NOP (o_opcode_D=7'h13, o_imm_D=0, o_rd_D=0).
- Register file: 32x32, x0 reads 0 always; writes to x0 ignored.
  - Write on posedge clk when i_wr_en_W.
  - Reads are combinational with write-through: if i_wr_en_W, addr==rs, and rs!=0, return i_wr_data_W the same cycle.
  - rst==0 clears all registers.
- Immediate by opcode (all sign-extended from instr[31]):
  - I: 0x03, 0x13, 0x67
  - S: 0x23
  - B: 0x63
  - U: 0x37, 0x17, imm = instr[31:12]<<12
  - J: 0x6F
  - other opcodes: 0
- Branch resolution (combinational, same cycle):
  - PC_D = o_PC_plus4_D - 4.
  - Operands A/B are forwarded per i_fwd_a_D/i_fwd_b_D.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU on funct3 (000,001,100,101,110,111); funct3 010/011 is never taken.
  - Target: B-type = PC_D+imm; JAL = PC_D+imm; JALR = (A+imm) & ~32'h1.
  - All arithmetic is 32-bit modulo, with wrap-around permitted.
- o_sel_PC_D = valid & i_en & (taken branch | JAL | JALR).
  - Forced 0 while stalled, so a redirect fires exactly once, on the cycle the stall releases.
- o_PC_branch_D is always driven with the computed target; it is don't-care when sel=0.
- A write to a source register in the same cycle the branch reads it is seen through write-through.
- Reset mid-stall or mid-redirect: reset wins; no redirect is issued that cycle.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - funct3 branch codes
  - NOP encoding
  - imm_type_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
- One sub-module: register_file (2 async read ports with write-through, 1 sync write port, x0 zero).
- IF/ID register, immediate generator and branch unit stay in decode_stage.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release. Required: o_valid_D=0, o_sel_PC_D=0, o_opcode_D=7'h13, o_PC_plus4_D=4.
- Regfile write-through: write x5=0xDEADBEEF while D holds instr 0x00028093 (addi x1,x5,0). Required: o_rd1_D=0xDEADBEEF the same cycle. A write to x0 leaves x0 reading 0.
- BEQ taken and squash:
  - Setup: x1=x2=7; D holds beq x1,x2,+16 at PC 0x100 (o_PC_plus4_D=0x104).
  - Required: o_sel_PC_D=1 and o_PC_branch_D=0x110.
  - Next cycle: o_valid_D=0 and D holds NOP.
- BLTU not taken vs BLT taken with A=0xFFFFFFFF, B=1. Required: BLTU sel=0; BLT sel=1.
- JALR with forwarding: i_fwd_a_D=1, i_ALU_result_M=0x2003, imm=+4. Required: o_PC_branch_D=0x2006 (bit0 cleared... 0x2007&~1) and sel=1.
- Stall on branch: BEQ taken with i_en=0 for 3 cycles. Required: sel=0 and IF/ID held for those 3 cycles. When i_en returns to 1: sel=1 for exactly one cycle, then a squash.
